// File: rtl/ksa_seq_ctrl.sv
// ksa_seq_ctrl: multi-precision add/subtract sequencer for one shared external
// 16-bit Kogge-Stone adder. It has no carry-in, so each limb needs two passes.
// Operand limbs A[i] and B[i] are loaded over Wishbone. Pass 1 adds the limbs.
// Pass 2 adds the carry coming in from the limb below. The result limbs R[i],
// the final carry (COUT) and a sticky DONE flag can then be read back. An
// optional one-cycle irq pulse marks completion.
//
// Ports:
//   wb_clk_i, wb_rst_n        clock; asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i      Wishbone cycle, strobe, write enable
//   wbs_sel_i                 byte selects (unused, full-word access only)
//   wbs_adr_i, wbs_dat_i      byte address, write data
//   wbs_ack_o, wbs_dat_o      registered acknowledge and read data
//   ksa_a, ksa_b              operands driven to the external adder
//   ksa_sum, ksa_cout         combinational adder result, same cycle
//   irq                       completion pulse, one cycle, gated by CTRL.IE
module ksa_seq_ctrl #(
  parameter int          NLIMBS    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] ksa_a,
  output logic [15:0] ksa_b,
  input  logic [15:0] ksa_sum,
  input  logic        ksa_cout,
  output logic        irq
);

  localparam int IDX_W = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMBS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_CARRY
  } state_t;

  // Architectural state
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      a_q [NLIMBS];
  logic [15:0]      a_d [NLIMBS];
  logic [15:0]      b_q [NLIMBS];
  logic [15:0]      b_d [NLIMBS];
  logic [15:0]      r_q [NLIMBS];
  logic [15:0]      r_d [NLIMBS];
  logic [15:0]      tmp_q, tmp_d;     // pass-1 partial sum of the current limb
  logic             c_q, c_d;         // carry entering the current limb
  logic             c1_q, c1_d;       // carry out of pass 1
  logic             sub_q, sub_d;
  logic             ie_q, ie_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             irq_q, irq_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;

  // Bus decode
  logic [7:0] off;
  logic       bus_valid;
  logic       bus_acc;
  logic       bus_wr;
  logic       bus_rd;
  logic       busy;
  logic       sel_ctrl;
  logic       sel_stat;
  logic       aligned;
  logic       start;
  logic       c_nxt;

  assign off       = wbs_adr_i[7:0];
  assign bus_valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // A transfer is accepted only while ack is low, so every access takes two
  // cycles and the ack edge is the only edge on which a write can land.
  assign bus_acc   = bus_valid & ~ack_q;
  assign bus_wr    = bus_acc & wbs_we_i;
  assign bus_rd    = bus_acc & ~wbs_we_i;
  assign busy      = (state_q != ST_IDLE);
  assign sel_ctrl  = (off == 8'h00);
  assign sel_stat  = (off == 8'h04);
  assign aligned   = (off[1:0] == 2'b00);
  assign start     = bus_wr & ~busy & sel_ctrl & wbs_dat_i[0];

  // Byte selects and the upper half of write data carry no information here.
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_dat_i[31:16]};

  always_comb begin
    // NOTE: every variable gets a default before any branch. Without the
    // default, a path that skips an assignment infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    tmp_d   = tmp_q;
    c_d     = c_q;
    c1_d    = c1_q;
    sub_d   = sub_q;
    ie_d    = ie_q;
    done_d  = done_q;
    cout_d  = cout_q;
    irq_d   = 1'b0;
    ack_d   = bus_acc;
    dat_d   = '0;
    ksa_a   = '0;
    ksa_b   = '0;
    c_nxt   = 1'b0;

    // Register reads, captured on the ack edge
    if (bus_rd) begin
      if (sel_ctrl) begin
        dat_d = {29'h0, ie_q, sub_q, 1'b0};
      end else if (sel_stat) begin
        dat_d = {29'h0, cout_q, done_q, busy};
      end else if (aligned) begin
        for (int k = 0; k < NLIMBS; k++) begin
          if (off[5:2] == 4'(k)) begin
            case (off[7:6])
              2'b01:   dat_d = {16'h0, a_q[k]};
              2'b10:   dat_d = {16'h0, b_q[k]};
              2'b11:   dat_d = {16'h0, r_q[k]};
              default: dat_d = '0;
            endcase
          end
        end
      end
    end

    // Configuration and operand writes are frozen while a run is in flight.
    if (bus_wr && !busy) begin
      if (sel_ctrl) begin
        sub_d = wbs_dat_i[1];
        ie_d  = wbs_dat_i[2];
      end
      if (aligned) begin
        for (int k = 0; k < NLIMBS; k++) begin
          if (off[5:2] == 4'(k)) begin
            if (off[7:6] == 2'b01) a_d[k] = wbs_dat_i[15:0];
            if (off[7:6] == 2'b10) b_d[k] = wbs_dat_i[15:0];
          end
        end
      end
    end

    // DONE write-1-to-clear is honoured at any time. The FSM below runs after
    // it, so a completion on the same edge wins.
    if (bus_wr && sel_stat && wbs_dat_i[1]) done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADD;
          idx_d   = '0;
          c_d     = wbs_dat_i[1];   // subtract seeds the two's-complement +1
          done_d  = 1'b0;
        end
      end
      ST_ADD: begin
        ksa_a   = a_q[idx_q];
        ksa_b   = sub_q ? ~b_q[idx_q] : b_q[idx_q];
        tmp_d   = ksa_sum;
        c1_d    = ksa_cout;
        state_d = ST_CARRY;
      end
      ST_CARRY: begin
        // This pass runs even when the incoming carry is 0, which keeps the
        // latency fixed. At most one of the two passes can carry out.
        ksa_a      = tmp_q;
        ksa_b      = {15'h0, c_q};
        r_d[idx_q] = ksa_sum;
        c_nxt      = c1_q | ksa_cout;
        c_d        = c_nxt;
        if (idx_q == LAST_IDX) begin
          cout_d  = c_nxt;
          done_d  = 1'b1;
          irq_d   = ie_q;
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_ADD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the operand and result arrays are register state visible on the
  // bus and must read 0 after reset, so they are reset like every other flop
  // rather than being left as uninitialised RAM.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      r_q     <= '{default: '0};
      tmp_q   <= '0;
      c_q     <= 1'b0;
      c1_q    <= 1'b0;
      sub_q   <= 1'b0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of every other flop. Blocking assignments here would let the
      // result depend on statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      tmp_q   <= tmp_d;
      c_q     <= c_d;
      c1_q    <= c1_d;
      sub_q   <= sub_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_ksa_seq_ctrl.sv
// Testbench for ksa_seq_ctrl. A behavioural Kogge-Stone stand-in (a plain
// 16-bit add) is attached to the adder ports. Bus tasks push the expected read
// data into a queue. A separate monitor pops one entry and compares it on every
// read acknowledge. Cycle-exact properties such as BUSY duration, DONE
// set-vs-clear and irq width are checked by landing accesses on chosen edges.
module tb_ksa_seq_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] ksa_a, ksa_b, ksa_sum;
  logic        ksa_cout;
  logic        irq;

  ksa_seq_ctrl #(.NLIMBS(4), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .ksa_a    (ksa_a),
    .ksa_b    (ksa_b),
    .ksa_sum  (ksa_sum),
    .ksa_cout (ksa_cout),
    .irq      (irq)
  );

  // Adder stand-in
  assign {ksa_cout, ksa_sum} = {1'b0, ksa_a} + {1'b0, ksa_b};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int irq_cycles = 0;
  int irq_last = -1;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare read data on each read ack, and count irq cycles
  always @(posedge clk) begin
    #1;
    if (wbs_ack_o && !we) begin
      if (exp_q.size() == 0) begin
        check("unexpected read ack", 64'd1, 64'd0);
      end else begin
        check(name_q.pop_front(), {32'h0, wbs_dat_o}, {32'h0, exp_q.pop_front()});
      end
    end
    if (irq) begin
      irq_cycles++;
      irq_last = cyc_cnt;
    end
  end

  // One Wishbone access. Called at a negedge and returns at a negedge. The
  // ack edge number is returned so that later accesses can be timed from it.
  task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d,
                     input logic [31:0] exp, input string nm, output int ack_cyc);
    logic got = 1'b0;
    if (!w) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {24'h0, off}; wdat = d;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) got = 1'b1;
    end
    ack_cyc = cyc_cnt;
    check({"ack ", nm}, {63'h0, got}, 64'd1);
    if (!got && !w) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input string nm);
    int c;
    bus(1'b1, off, d, 32'h0, nm, c);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
    int c;
    bus(1'b0, off, 32'h0, exp, nm, c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] b);
    for (int k = 0; k < 4; k++) begin
      wr(8'(8'h40 + 4 * k), {16'h0, a[16*k +: 16]}, $sformatf("wr A[%0d]", k));
      wr(8'(8'h80 + 4 * k), {16'h0, b[16*k +: 16]}, $sformatf("wr B[%0d]", k));
    end
  endtask

  task automatic read_r(input logic [63:0] r, input string tag);
    for (int k = 0; k < 4; k++)
      rd(8'(8'hC0 + 4 * k), {16'h0, r[16*k +: 16]}, $sformatf("%s R[%0d]", tag, k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int irq0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset ksa_a", {48'h0, ksa_a}, 64'h0);
    check("reset ksa_b", {48'h0, ksa_b}, 64'h0);
    check("reset ack", {63'h0, wbs_ack_o}, 64'h0);
    check("reset dat_o", {32'h0, wbs_dat_o}, 64'h0);
    check("reset irq", {63'h0, irq}, 64'h0);
    rd(8'h04, 32'h0, "reset STATUS");
    rd(8'h00, 32'h0, "reset CTRL");
    rd(8'h40, 32'h0, "reset A[0]");

    // Unmapped offsets and an out-of-range limb
    wr(8'h20, 32'hDEAD_BEEF, "wr unmapped");
    rd(8'h20, 32'h0, "unmapped 0x20");
    rd(8'h0C, 32'h0, "unmapped 0x0C");
    rd(8'h50, 32'h0, "A[4] out of range");

    // Test 1: 0xFFFF + 1 carries into limb 1; BUSY lasts exactly 8 cycles
    load(64'h0000_0000_0000_FFFF, 64'h1);
    rd(8'h40, 32'h0000_FFFF, "readback A[0]");
    rd(8'h80, 32'h0000_0001, "readback B[0]");
    bus(1'b1, 8'h00, 32'h1, 32'h0, "start add1", e0);
    idle(7);
    rd(8'h04, 32'h1, "STATUS busy at start+8");
    idle(4);
    read_r(64'h0000_0000_0001_0000, "add1");
    bus(1'b1, 8'h00, 32'h1, 32'h0, "start add1b", e0);
    idle(8);
    rd(8'h04, 32'h2, "STATUS idle at start+9");

    // Test 2: all-ones + 1 wraps to 0 with COUT; irq one cycle on final edge
    load(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    irq0 = irq_cycles;
    bus(1'b1, 8'h00, 32'h5, 32'h0, "start add2", e0);
    idle(12);
    check("irq width add2", 64'(irq_cycles - irq0), 64'd1);
    check("irq edge add2", 64'(irq_last), 64'(e0 + 8));
    read_r(64'h0, "add2");
    rd(8'h04, 32'h6, "STATUS add2");
    rd(8'h00, 32'h4, "CTRL IE readback");

    // Test 3: subtract with and without borrow
    load(64'h5, 64'h7);
    wr(8'h00, 32'h3, "start sub 5-7");
    idle(12);
    read_r(64'hFFFF_FFFF_FFFF_FFFE, "5-7");
    rd(8'h04, 32'h2, "STATUS 5-7");
    load(64'h7, 64'h5);
    wr(8'h00, 32'h3, "start sub 7-5");
    idle(12);
    read_r(64'h2, "7-5");
    rd(8'h04, 32'h6, "STATUS 7-5");

    // Test 4: A write and a second START while BUSY are acked but dropped
    irq0 = irq_cycles;
    wr(8'h00, 32'h7, "start sub busy test");
    wr(8'h40, 32'h1234, "wr A[0] while busy");
    wr(8'h00, 32'h1, "start while busy");
    idle(14);
    check("single completion", 64'(irq_cycles - irq0), 64'd1);
    rd(8'h40, 32'h7, "A[0] unchanged");
    rd(8'hC0, 32'h2, "R[0] old operands");
    rd(8'h00, 32'h6, "CTRL unchanged");
    rd(8'h04, 32'h6, "STATUS busy test");

    // Test 5: W1C on the completion edge loses; one edge later it clears
    bus(1'b1, 8'h00, 32'h3, 32'h0, "start w1c race", e0);
    idle(7);
    wr(8'h04, 32'h2, "W1C on completion edge");
    rd(8'h04, 32'h6, "DONE set wins");
    bus(1'b1, 8'h00, 32'h3, 32'h0, "start w1c late", e0);
    idle(8);
    wr(8'h04, 32'h2, "W1C one edge later");
    rd(8'h04, 32'h4, "DONE cleared");

    // Test 6: reset in the middle of an operation
    load(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    irq0 = irq_cycles;
    bus(1'b1, 8'h00, 32'h5, 32'h0, "start abort", e0);
    idle(2);
    check("mid-op ksa_a", {48'h0, ksa_a}, 64'hFFFF);
    rst_n = 1'b0;
    #1;
    check("abort ksa_a", {48'h0, ksa_a}, 64'h0);
    check("abort ksa_b", {48'h0, ksa_b}, 64'h0);
    check("abort ack", {63'h0, wbs_ack_o}, 64'h0);
    check("abort dat_o", {32'h0, wbs_dat_o}, 64'h0);
    check("abort irq", {63'h0, irq}, 64'h0);
    idle(3);
    rst_n = 1'b1;
    idle(12);
    check("no irq after abort", 64'(irq_cycles - irq0), 64'd0);
    rd(8'h04, 32'h0, "STATUS after abort");
    rd(8'h00, 32'h0, "CTRL after abort");
    rd(8'h40, 32'h0, "A[0] after abort");
    read_r(64'h0, "abort");

    idle(4);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
